// File: rtl/disp_ctrl.sv
// disp_ctrl -- multiplexed digit display refresh and time-set controller.
//
// Purpose:
//   * Refresh: walks digit 0..NDIG-1 through an external shift register
//     (select via o_muxsel, load via o_srload, wait for i_srbusy to drop),
//     then strobes o_latch to transfer the completed frame to the display.
//   * Timebase: o_cnt_en pulses once every PRESCALE clocks.
//   * Time set: holding i_set steps a target field (0 = run mode,
//     k = field k-1) every HOLD_CYC clocks; each rising edge of i_up with a
//     field targeted produces a one-cycle one-hot strobe on o_set_en.
//
// Optional feature (macro DISP_CTRL_BLINK_EN):
//   The targeted field blinks. A blink phase toggles after every
//   BLINK_FRAMES o_latch pulses, and while the phase is 1 the digits of the
//   targeted field are replaced by the BLANK_SEL mux code. Without the macro
//   o_muxsel is always the digit index.
//
// Ports:
//   i_clk     in   1       clock, rising edge
//   i_rst     in   1       asynchronous active-high reset
//   o_muxsel  out  SEL_W   digit source select for the shift register
//   i_srbusy  in   1       shift register busy
//   o_srload  out  1       one-cycle shift register load strobe
//   o_latch   out  1       one-cycle frame latch strobe
//   o_cnt_en  out  1       one-cycle timekeeping enable
//   i_set     in   1       field-select button level
//   i_up      in   1       increment button level
//   o_set_en  out  FIELDS  one-hot per-field increment strobe
module disp_ctrl #(
  parameter int NDIG          = 6,
  parameter int DIG_PER_FIELD = 2,
  parameter int SEL_W         = 3,
  parameter int BLANK_SEL     = 6,
  parameter int PRESCALE      = 512,
  parameter int HOLD_CYC      = 512,
  parameter int BLINK_FRAMES  = 1,
  localparam int FIELDS       = NDIG / DIG_PER_FIELD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [SEL_W-1:0]  o_muxsel,
  input  logic              i_srbusy,
  output logic              o_srload,
  output logic              o_latch,
  output logic              o_cnt_en,
  input  logic              i_set,
  input  logic              i_up,
  output logic [FIELDS-1:0] o_set_en
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int HOLD_W = $clog2(HOLD_CYC);
  localparam int DIG_W  = $clog2(NDIG + 1);
  localparam int TGT_W  = $clog2(FIELDS + 1);

  // Elaboration-time parameter sanity checks
  if (NDIG % DIG_PER_FIELD != 0) begin : g_chk_fields
    $error("disp_ctrl: NDIG must be a multiple of DIG_PER_FIELD");
  end
  if (NDIG >= (1 << SEL_W)) begin : g_chk_sel
    $error("disp_ctrl: NDIG must be below 2**SEL_W");
  end
  if (BLANK_SEL < NDIG || BLANK_SEL >= (1 << SEL_W)) begin : g_chk_blank
    $error("disp_ctrl: BLANK_SEL must lie in [NDIG, 2**SEL_W)");
  end
  if (PRESCALE < 2 || HOLD_CYC < 2 || BLINK_FRAMES < 1) begin : g_chk_counts
    $error("disp_ctrl: PRESCALE and HOLD_CYC must be >= 2, BLINK_FRAMES >= 1");
  end

  typedef enum logic [1:0] {
    S_WAIT,
    S_LOAD,
    S_GAP,
    S_LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic               up_prev_q, up_prev_d;
  logic [FIELDS-1:0]  set_en_q, set_en_d;
  logic               up_rise;
  logic               blank;

  // Refresh FSM: next state and Moore strobes
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    o_srload = 1'b0;
    o_latch  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (!i_srbusy) begin
          state_d = (digit_q == DIG_W'(NDIG)) ? S_LATCH : S_LOAD;
        end
      end
      S_LOAD: begin
        o_srload = 1'b1;
        digit_d  = digit_q + DIG_W'(1);
        state_d  = S_GAP;
      end
      // One idle cycle so the shift register can raise busy before WAIT samples it
      S_GAP: begin
        state_d = S_WAIT;
      end
      S_LATCH: begin
        o_latch = 1'b1;
        digit_d = '0;
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // Prescaler, hold counter, target field and increment strobe
  always_comb begin
    pre_d     = (pre_q == PRE_W'(PRESCALE - 1)) ? '0 : pre_q + PRE_W'(1);
    hold_d    = '0;
    tgt_d     = tgt_q;
    up_prev_d = i_up;
    if (i_set) begin
      if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
        hold_d = '0;
        tgt_d  = (tgt_q == TGT_W'(FIELDS)) ? '0 : tgt_q + TGT_W'(1);
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
    // Decoded from the current (pre-advance) target
    up_rise = i_up && !up_prev_q;
    for (int k = 0; k < FIELDS; k++) begin
      set_en_d[k] = up_rise && (int'(tgt_q) == k + 1);
    end
  end

  assign o_cnt_en = (pre_q == PRE_W'(PRESCALE - 1));
  assign o_set_en = set_en_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_WAIT;
      digit_q   <= '0;
      pre_q     <= '0;
      hold_q    <= '0;
      tgt_q     <= '0;
      // Starts high so a button already held through reset is not an edge
      up_prev_q <= 1'b1;
      set_en_q  <= '0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      pre_q     <= pre_d;
      hold_q    <= hold_d;
      tgt_q     <= tgt_d;
      up_prev_q <= up_prev_d;
      set_en_q  <= set_en_d;
    end
  end

`ifdef DISP_CTRL_BLINK_EN
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             phase_q, phase_d;
  logic [FRM_W-1:0] frm_q, frm_d;

  always_comb begin
    phase_d = phase_q;
    frm_d   = frm_q;
    if (o_latch) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= 1'b0;
      frm_q   <= '0;
    end else begin
      phase_q <= phase_d;
      frm_q   <= frm_d;
    end
  end

  // Blank only the digits belonging to the field being set
  assign blank = (tgt_q != '0) && phase_q &&
                 ((int'(digit_q) / DIG_PER_FIELD) == (int'(tgt_q) - 1));
`else
  assign blank = 1'b0;
`endif

  assign o_muxsel = blank ? SEL_W'(BLANK_SEL) : SEL_W'(digit_q);

endmodule
